instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 30 +++
 rtl/branch_target_adder.sv | 12 +
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and PC constants.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

  localparam logic [31:0] RESET_PC       = 32'h0000_0000;
  localparam logic [31:0] PC_INC         = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory handshake plus pipeline-facing signals of the fetch unit.
interface instr_fetch_if;

  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck;
  logic [31:0] IRdata;
  logic        Stall;
  logic        Branch;
  logic [31:0] ExtImm;
  logic        RedirectEn;
  logic [31:0] RedirectAddr;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus8;

  // Fetch unit side.
  modport master (
    output IReq, IAddr, InstrValid, Instr, InstrPC, PCPlus8,
    input  IAck, IRdata, Stall, Branch, ExtImm, RedirectEn, RedirectAddr
  );

  // Memory / datapath side.
  modport slave (
    input  IReq, IAddr, InstrValid, Instr, InstrPC, PCPlus8,
    output IAck, IRdata, Stall, Branch, ExtImm, RedirectEn, RedirectAddr
  );

endinterface

// File: rtl/branch_target_adder.sv
// Branch target: architectural PC read value (InstrPC+8) plus the extended offset.
module branch_target_adder
  import instr_fetch_pkg::*;
(
  input  logic [31:0] instr_pc_i,
  input  logic [31:0] ext_imm_i,
  output logic [31:0] target_o
);

  assign target_o = instr_pc_i + PC_READ_OFFSET + ext_imm_i;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read, a single presented instruction,
// branch and datapath redirects. A redirect while a read is in flight drains that read.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic          CLK,
  input  logic          Reset,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  iaddr_q, iaddr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  branch_target;
  logic [31:0]  redirect_pc;

  branch_target_adder u_branch_target_adder (
    .instr_pc_i (instr_pc_q),
    .ext_imm_i  (bus.ExtImm),
    .target_o   (branch_target)
  );

  assign redirect_pc = align_word(bus.RedirectAddr);

  // Next-state logic: redirect wins over branch and stall in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      StFetch: begin
        if (bus.RedirectEn) begin
          pc_d = redirect_pc;
          // Data returning alongside a redirect belongs to the old stream.
          state_d = bus.IAck ? StFetch : StDrain;
        end else if (bus.IAck) begin
          instr_d    = bus.IRdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_INC;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (bus.RedirectEn) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!bus.Stall) begin
          if (bus.Branch && valid_q) begin
            pc_d = branch_target;
          end
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (bus.RedirectEn) begin
          pc_d = redirect_pc;
        end
        if (bus.IAck) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    // The request address only moves when a new request is about to be issued.
    iaddr_d = (state_d == StFetch) ? pc_d : iaddr_q;
  end

  // State register with synchronous reset; an IAck in the reset cycle is dropped.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      iaddr_q    <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iaddr_q    <= iaddr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.IReq       = (state_q != StHold) && !Reset;
  assign bus.IAddr      = iaddr_q;
  assign bus.InstrValid = valid_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrPC    = instr_pc_q;
  assign bus.PCPlus8    = instr_pc_q + PC_READ_OFFSET;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction-level model.
module tb_instr_fetch;

  logic CLK;
  logic Reset;

  instr_fetch_if bus ();

  instr_fetch dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding read (possibly marked for discard) or one held instruction.
  bit          m_init = 0;
  bit          m_req_active;
  bit          m_discard;
  logic [31:0] m_req_addr;
  logic [31:0] m_pc;
  bit          m_have;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  always @(posedge CLK) begin
    logic [31:0] na;
    na = {bus.RedirectAddr[31:2], 2'b00};
    if (Reset) begin
      m_init       = 1;
      m_pc         = 32'h0;
      m_req_active = 1;
      m_req_addr   = 32'h0;
      m_discard    = 0;
      m_have       = 0;
      m_instr      = 32'h0;
      m_ipc        = 32'h0;
    end else if (m_init) begin
      if (m_req_active) begin
        if (bus.IAck) begin
          if (!m_discard && !bus.RedirectEn) begin
            m_have  = 1;
            m_instr = bus.IRdata;
            m_ipc   = m_req_addr;
            m_pc    = m_req_addr + 32'd4;
          end
          if (bus.RedirectEn) m_pc = na;
          m_req_active = !m_have;
          m_req_addr   = m_pc;
          m_discard    = 0;
        end else if (bus.RedirectEn) begin
          m_pc      = na;
          m_discard = 1;
        end
      end else begin
        if (bus.RedirectEn) begin
          m_pc   = na;
          m_have = 0;
        end else if (!bus.Stall) begin
          if (bus.Branch) m_pc = m_ipc + 32'd8 + bus.ExtImm;
          m_have = 0;
        end
        if (!m_have) begin
          m_req_active = 1;
          m_req_addr   = m_pc;
          m_discard    = 0;
        end
      end
    end
  end

  // Every-cycle comparison, sampled mid-cycle.
  always @(negedge CLK) begin
    if (m_init) begin
      logic exp_req;
      exp_req = m_req_active && !Reset;
      check("IReq", {31'b0, bus.IReq}, {31'b0, exp_req});
      if (exp_req) check("IAddr", bus.IAddr, m_req_addr);
      check("InstrValid", {31'b0, bus.InstrValid}, {31'b0, m_have});
      check("Instr", bus.Instr, m_instr);
      check("InstrPC", bus.InstrPC, m_ipc);
      check("PCPlus8", bus.PCPlus8, m_ipc + 32'd8);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          ack_cnt;
    logic [23:0] r24;

    Reset            = 1'b1;
    bus.IAck         = 1'b0;
    bus.IRdata       = '0;
    bus.Stall        = 1'b0;
    bus.Branch       = 1'b0;
    bus.ExtImm       = '0;
    bus.RedirectEn   = 1'b0;
    bus.RedirectAddr = '0;
    cyc();
    cyc();

    // Reset state.
    check("rst_ireq", {31'b0, bus.IReq}, 32'd0);
    check("rst_valid", {31'b0, bus.InstrValid}, 32'd0);
    check("rst_iaddr", bus.IAddr, 32'h0);
    check("rst_instr", bus.Instr, 32'h0);
    check("rst_instrpc", bus.InstrPC, 32'h0);
    Reset = 1'b0;
    #1;
    check("rel_ireq", {31'b0, bus.IReq}, 32'd1);

    // Sequential fetch from 0.
    bus.IAck = 1'b1; bus.IRdata = 32'hE3A0_0001;
    cyc();
    bus.IAck = 1'b0;
    check("seq0_valid", {31'b0, bus.InstrValid}, 32'd1);
    check("seq0_instr", bus.Instr, 32'hE3A0_0001);
    check("seq0_instrpc", bus.InstrPC, 32'h0);
    check("seq0_pcplus8", bus.PCPlus8, 32'h8);
    cyc();
    check("seq1_ireq", {31'b0, bus.IReq}, 32'd1);
    check("seq1_iaddr", bus.IAddr, 32'h4);
    bus.IAck = 1'b1; bus.IRdata = 32'hE3A0_0002;
    cyc();
    bus.IAck = 1'b0;
    check("seq1_instrpc", bus.InstrPC, 32'h4);
    cyc();
    check("seq2_iaddr", bus.IAddr, 32'h8);

    // Redirect together with IAck: data dropped, refetch at the redirect target.
    bus.RedirectEn = 1'b1; bus.RedirectAddr = 32'h100;
    bus.IAck = 1'b1; bus.IRdata = 32'hBAD0_BAD0;
    cyc();
    bus.RedirectEn = 1'b0; bus.IAck = 1'b0;
    check("rdack_valid", {31'b0, bus.InstrValid}, 32'd0);
    check("rdack_iaddr", bus.IAddr, 32'h100);

    // Backward branch by -8 from 0x100 lands on 0x100.
    bus.IAck = 1'b1; bus.IRdata = 32'hEAFF_FFFE;
    cyc();
    bus.IAck = 1'b0;
    check("br_instrpc", bus.InstrPC, 32'h100);
    bus.Branch = 1'b1; bus.ExtImm = 32'hFFFF_FFF8;
    cyc();
    bus.Branch = 1'b0;
    check("br_iaddr", bus.IAddr, 32'h100);

    // Stall for 5 cycles; Branch must be ignored while stalled.
    bus.IAck = 1'b1; bus.IRdata = 32'h1234_5678;
    cyc();
    bus.IAck = 1'b0; bus.Stall = 1'b1; bus.Branch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_ireq", {31'b0, bus.IReq}, 32'd0);
      check("stall_valid", {31'b0, bus.InstrValid}, 32'd1);
      check("stall_instr", bus.Instr, 32'h1234_5678);
    end
    bus.Stall = 1'b0; bus.Branch = 1'b0;
    cyc();
    check("stall_resume", bus.IAddr, 32'h104);

    // Redirect while a read is outstanding: drain, then fetch at aligned target.
    bus.RedirectEn = 1'b1; bus.RedirectAddr = 32'h2003;
    cyc();
    bus.RedirectEn = 1'b0;
    check("drain_ireq", {31'b0, bus.IReq}, 32'd1);
    check("drain_iaddr", bus.IAddr, 32'h104);
    cyc();
    cyc();
    bus.IAck = 1'b1; bus.IRdata = 32'hDEAD_BEEF;
    cyc();
    bus.IAck = 1'b0;
    check("drain_valid", {31'b0, bus.InstrValid}, 32'd0);
    check("drain_next", bus.IAddr, 32'h2000);
    bus.IAck = 1'b1; bus.IRdata = 32'h1111_1111;
    cyc();
    bus.IAck = 1'b0;
    check("drain_instr", bus.Instr, 32'h1111_1111);
    check("drain_instrpc", bus.InstrPC, 32'h2000);

    // PC wrap at the top of the address space.
    bus.RedirectEn = 1'b1; bus.RedirectAddr = 32'hFFFF_FFFC;
    cyc();
    bus.RedirectEn = 1'b0;
    check("wrap_iaddr0", bus.IAddr, 32'hFFFF_FFFC);
    bus.IAck = 1'b1; bus.IRdata = 32'h0000_0055;
    cyc();
    bus.IAck = 1'b0;
    check("wrap_pcplus8", bus.PCPlus8, 32'h4);
    cyc();
    check("wrap_iaddr1", bus.IAddr, 32'h0);

    // Reset mid-request with an IAck in the reset cycle.
    bus.IAck = 1'b1;
    cyc();
    bus.IAck = 1'b0;
    cyc();
    check("mid_iaddr", bus.IAddr, 32'h4);
    Reset = 1'b1; bus.IAck = 1'b1; bus.IRdata = 32'h7777_7777;
    cyc();
    check("midrst_ireq", {31'b0, bus.IReq}, 32'd0);
    check("midrst_valid", {31'b0, bus.InstrValid}, 32'd0);
    check("midrst_iaddr", bus.IAddr, 32'h0);
    Reset = 1'b0; bus.IAck = 1'b0;
    cyc();

    // Randomized traffic; memory acks after 0..3 wait cycles.
    ack_cnt = $urandom_range(0, 3);
    for (int n = 0; n < 4000; n++) begin
      if (bus.IReq) begin
        if (ack_cnt == 0) begin
          bus.IAck   = 1'b1;
          bus.IRdata = $urandom;
          ack_cnt    = $urandom_range(0, 3);
        end else begin
          bus.IAck = 1'b0;
          ack_cnt--;
        end
      end else begin
        bus.IAck = 1'b0;
      end
      bus.Stall        = ($urandom_range(0, 3) == 0);
      bus.Branch       = ($urandom_range(0, 2) == 0);
      r24              = 24'($urandom);
      bus.ExtImm       = {{6{r24[23]}}, r24, 2'b00};
      bus.RedirectEn   = ($urandom_range(0, 15) == 0);
      bus.RedirectAddr = $urandom;
      Reset            = ($urandom_range(0, 255) == 0);
      cyc();
    end

    Reset = 1'b0;
    bus.IAck = 1'b0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
